// File: rtl/vga_fetch_arbiter.sv
// vga_fetch_arbiter
//   Shares one single-port pixel memory between the host write path and
//   line-buffer prefetch bursts requested by the VGA timing generator.
//   Prefetch always wins. A burst issues BURST_LEN consecutive reads
//   starting at fetch_base (wrapping modulo 2^AW), copies each returned
//   word into the line buffer, then spends one DRAIN cycle flushing the
//   final word before returning to IDLE.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_start, fetch_base    line prefetch request and first word address
//   host_valid/host_ready      host write handshake (host_ready is combinational)
//   host_addr, host_data       host write address / data
//   mem_en, mem_we             memory strobe / write enable (registered)
//   mem_addr, mem_wdata        memory address / write data (registered)
//   mem_rdata                  memory read data, valid one cycle after a read
//   lb_we, lb_addr, lb_wdata   line-buffer write port (lb_wdata = mem_rdata)
//   fetch_done, busy           burst-complete pulse / burst in progress
//   underrun, underrun_clr     sticky "fetch_start while busy" flag and clear
//
// Configuration
//   VGA_FETCH_UNDERRUN_EN      when defined, ignored fetch requests set the
//                              sticky underrun flag; otherwise underrun is 0.

module vga_fetch_arbiter #(
  parameter int unsigned AW        = 13,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_LEN = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_start,
  input  logic [AW-1:0]                fetch_base,
  input  logic                         host_valid,
  output logic                         host_ready,
  input  logic [AW-1:0]                host_addr,
  input  logic [DW-1:0]                host_data,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  input  logic [DW-1:0]                mem_rdata,
  output logic                         lb_we,
  output logic [$clog2(BURST_LEN)-1:0] lb_addr,
  output logic [DW-1:0]                lb_wdata,
  output logic                         fetch_done,
  output logic                         busy,
  output logic                         underrun,
  input  logic                         underrun_clr
);

  localparam int unsigned LBW = $clog2(BURST_LEN);
  localparam logic [LBW-1:0] LAST_IDX = LBW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  logic [LBW-1:0] cnt;
  logic           host_fire;

  // Host is admitted only when idle and no prefetch is arriving this cycle.
  assign host_ready = (state == IDLE) && !fetch_start;
  assign host_fire  = host_valid && host_ready;

  // Read data lands one cycle after its strobe, aligned with lb_we/lb_addr.
  assign lb_wdata = mem_rdata;

  // Arbitration FSM; all memory and line-buffer strobes are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lb_we      <= 1'b0;
      lb_addr    <= '0;
      fetch_done <= 1'b0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      lb_we      <= 1'b0;
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_start) begin
            // First read goes out in the first FETCH cycle.
            state    <= FETCH;
            busy     <= 1'b1;
            cnt      <= '0;
            mem_en   <= 1'b1;
            mem_addr <= fetch_base;
          end else if (host_fire) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= host_addr;
            mem_wdata <= host_data;
          end
        end
        FETCH: begin
          // The read in flight this cycle becomes a line-buffer write next cycle.
          lb_we   <= 1'b1;
          lb_addr <= cnt;
          if (cnt == LAST_IDX) begin
            state      <= DRAIN;
            fetch_done <= 1'b1;
          end else begin
            cnt      <= cnt + LBW'(1);
            mem_en   <= 1'b1;
            mem_addr <= mem_addr + AW'(1);
          end
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_FETCH_UNDERRUN_EN
  logic fetch_ignored;

  // A request arriving during FETCH or DRAIN is dropped and flagged.
  assign fetch_ignored = fetch_start && (state != IDLE);

  // Sticky flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (fetch_ignored) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end
`else
  logic unused_underrun_clr;

  assign unused_underrun_clr = underrun_clr;
  assign underrun            = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// tb_vga_fetch_arbiter
//   Directed bench for vga_fetch_arbiter with default parameters
//   (AW=13, DW=8, BURST_LEN=32). The memory model returns the low byte of
//   the read address one cycle after each read strobe. Inputs change 1 time
//   unit after the rising edge; outputs are sampled on the falling edge.

module tb_vga_fetch_arbiter;

  localparam int unsigned AW  = 13;
  localparam int unsigned DW  = 8;
  localparam int unsigned BL  = 32;
  localparam int unsigned LBW = 5;

`ifdef VGA_FETCH_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           fetch_start;
  logic [AW-1:0]  fetch_base;
  logic           host_valid;
  logic           host_ready;
  logic [AW-1:0]  host_addr;
  logic [DW-1:0]  host_data;
  logic           mem_en;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           lb_we;
  logic [LBW-1:0] lb_addr;
  logic [DW-1:0]  lb_wdata;
  logic           fetch_done;
  logic           busy;
  logic           underrun;
  logic           underrun_clr;

  int checks   = 0;
  int failures = 0;

  vga_fetch_arbiter #(.AW(AW), .DW(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_start  (fetch_start),
    .fetch_base   (fetch_base),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .lb_we        (lb_we),
    .lb_addr      (lb_addr),
    .lb_wdata     (lb_wdata),
    .fetch_done   (fetch_done),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  // Memory word n holds n[7:0]; read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0];
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish (actual running, required done)");
    $fatal(1);
  end

  // Full burst from base; a competing fetch_start is injected at read inj (-1 = none).
  task automatic do_burst(input logic [AW-1:0] base, input int inj, input string tag);
    logic [AW-1:0] ea;
    logic [AW-1:0] pa;
    logic [DW-1:0] ed;
    logic          eur;
    @(posedge clk); #1;
    fetch_start = 1'b1;
    fetch_base  = base;
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_ready: got %b want 0", tag, host_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_busy: got %b want 0", tag, busy);
    end
    for (int i = 0; i < BL; i++) begin
      @(posedge clk); #1;
      fetch_start = (i == inj);
      fetch_base  = (i == inj) ? 13'h0500 : base;
      @(negedge clk);
      ea  = AW'(base + AW'(i));
      eur = UR_EN && (inj >= 0) && (i > inj);
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea) begin
        failures++;
        $display("FAIL %s_read%0d: got en=%b we=%b addr=%h want en=1 we=0 addr=%h",
                 tag, i, mem_en, mem_we, mem_addr, ea);
      end
      checks++;
      if (busy !== 1'b1 || fetch_done !== 1'b0 || underrun !== eur) begin
        failures++;
        $display("FAIL %s_status%0d: got busy=%b done=%b ur=%b want busy=1 done=0 ur=%b",
                 tag, i, busy, fetch_done, underrun, eur);
      end
      checks++;
      if (i == 0) begin
        if (lb_we !== 1'b0) begin
          failures++;
          $display("FAIL %s_lb_first: got lb_we=%b want 0", tag, lb_we);
        end
      end else begin
        pa = AW'(base + AW'(i - 1));
        ed = pa[7:0];
        if (lb_we !== 1'b1 || lb_addr !== LBW'(i - 1) || lb_wdata !== ed) begin
          failures++;
          $display("FAIL %s_lb%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   tag, i - 1, lb_we, lb_addr, lb_wdata, i - 1, ed);
        end
      end
    end
    // DRAIN cycle
    @(posedge clk); #1;
    fetch_start = 1'b0;
    @(negedge clk);
    pa  = AW'(base + AW'(BL - 1));
    ed  = pa[7:0];
    eur = UR_EN && (inj >= 0);
    checks++;
    if (lb_we !== 1'b1 || lb_addr !== LBW'(BL - 1) || lb_wdata !== ed || fetch_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_drain_lb: got we=%b addr=%0d data=%h done=%b want we=1 addr=31 data=%h done=1",
               tag, lb_we, lb_addr, lb_wdata, fetch_done, ed);
    end
    checks++;
    if (mem_en !== 1'b0 || busy !== 1'b1 || host_ready !== 1'b0 || underrun !== eur) begin
      failures++;
      $display("FAIL %s_drain_status: got en=%b busy=%b ready=%b ur=%b want en=0 busy=1 ready=0 ur=%b",
               tag, mem_en, busy, host_ready, underrun, eur);
    end
    // Back in IDLE
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fetch_done !== 1'b0 || lb_we !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: got busy=%b done=%b lb_we=%b en=%b want all 0",
               tag, busy, fetch_done, lb_we, mem_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || lb_we !== 1'b0 || fetch_done !== 1'b0 ||
        busy !== 1'b0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: got en=%b we=%b lb_we=%b done=%b busy=%b ur=%b want all 0",
               mem_en, mem_we, lb_we, fetch_done, busy, underrun);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || lb_addr !== '0 || host_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: got addr=%h wdata=%h lb_addr=%0d ready=%b want 0 0 0 1",
               mem_addr, mem_wdata, lb_addr, host_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    do_burst(13'h0100, -1, "burst");
  endtask

  task automatic test_wrap();
    do_burst(13'h1FF0, -1, "wrap");
  endtask

  task automatic test_host();
    logic [AW-1:0] ta [3];
    logic [DW-1:0] td [3];
    ta[0] = 13'h0010; ta[1] = 13'h0011; ta[2] = 13'h0012;
    td[0] = 8'hA5;    td[1] = 8'h5A;    td[2] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        host_valid = 1'b1;
        host_addr  = ta[i];
        host_data  = td[i];
      end else begin
        host_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if (host_ready !== 1'b1) begin
          failures++;
          $display("FAIL host_ready%0d: got %b want 1", i, host_ready);
        end
      end
      if (i > 0) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ta[i-1] || mem_wdata !== td[i-1]) begin
          failures++;
          $display("FAIL host_write%0d: got en=%b we=%b addr=%h data=%h want 1 1 %h %h",
                   i - 1, mem_en, mem_we, mem_addr, mem_wdata, ta[i-1], td[i-1]);
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL host_quiet: got en=%b we=%b want 0 0", mem_en, mem_we);
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] ea;
    @(posedge clk); #1;
    fetch_start = 1'b1;
    fetch_base  = 13'h0400;
    host_valid  = 1'b1;
    host_addr   = 13'h0020;
    host_data   = 8'h3C;
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b0) begin
      failures++;
      $display("FAIL cont_ready0: got %b want 0", host_ready);
    end
    for (int i = 0; i <= BL; i++) begin
      @(posedge clk); #1;
      fetch_start = 1'b0;
      @(negedge clk);
      ea = AW'(13'h0400 + AW'(i));
      checks++;
      if (host_ready !== 1'b0 || mem_we !== 1'b0 || (i < BL && mem_addr !== ea)) begin
        failures++;
        $display("FAIL cont_busy%0d: got ready=%b we=%b addr=%h want ready=0 we=0 addr=%h",
                 i, host_ready, mem_we, mem_addr, ea);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_idle: got ready=%b busy=%b want 1 0", host_ready, busy);
    end
    @(posedge clk); #1;
    host_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'h0020 || mem_wdata !== 8'h3C) begin
      failures++;
      $display("FAIL cont_write: got en=%b we=%b addr=%h data=%h want 1 1 0020 3c",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin
      failures++;
      $display("FAIL cont_single: got en=%b want 0", mem_en);
    end
  endtask

  task automatic test_ignore();
    do_burst(13'h0300, 10, "ignore");
    @(posedge clk); #1;
    underrun_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (underrun !== UR_EN) begin
      failures++;
      $display("FAIL ignore_sticky: got %b want %b", underrun, UR_EN);
    end
    @(posedge clk); #1;
    underrun_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL ignore_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    fetch_start = 1'b1;
    fetch_base  = 13'h0080;
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      fetch_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || lb_we !== 1'b0 || fetch_done !== 1'b0 ||
        busy !== 1'b0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_strobes: got en=%b we=%b lb_we=%b done=%b busy=%b ur=%b want all 0",
               mem_en, mem_we, lb_we, fetch_done, busy, underrun);
    end
    checks++;
    if (mem_addr !== '0 || lb_addr !== '0) begin
      failures++;
      $display("FAIL rstmid_values: got addr=%h lb_addr=%0d want 0 0", mem_addr, lb_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fetch_done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_hold%0d: got done=%b busy=%b want 0 0", i, fetch_done, busy);
      end
    end
    rst_n = 1'b1;
    do_burst(13'h0200, -1, "after_rst");
  endtask

  initial begin
    fetch_start  = 1'b0;
    fetch_base   = '0;
    host_valid   = 1'b0;
    host_addr    = '0;
    host_data    = '0;
    underrun_clr = 1'b0;
    test_reset();
    test_burst();
    test_host();
    test_contention();
    test_wrap();
    test_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_fetch_arbiter.md
VGA_FETCH_ARBITER -- requirements
Module: vga_fetch_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 13, meaning pixel-memory address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning memory/line-buffer data width.
REQ-003 The block SHALL have parameter BURST_LEN, default 32, meaning words per line fetch; legal values are powers of 2 from 2 to 256.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port fetch_start  input  1  one-cycle line-prefetch request from the timing generator.
REQ-007 The block SHALL have port fetch_base  input  AW  first word address of the line, sampled with fetch_start.
REQ-008 The block SHALL have port host_valid, host_ready  input/output  1 each  host write handshake.
REQ-009 The block SHALL have ports host_addr, host_data  input  AW/DW  host write address and data.
REQ-010 The block SHALL have ports mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-011 The block SHALL have ports mem_addr, mem_wdata  output  AW/DW  registered memory address and write data.
REQ-012 The block SHALL have port mem_rdata  input  DW  read data, valid exactly one cycle after a read strobe.
REQ-013 The block SHALL have ports lb_we, lb_addr, lb_wdata  output  1/log2(BURST_LEN)/DW  line-buffer write port.
REQ-014 The block SHALL have ports fetch_done, busy  output  1 each  burst-complete pulse; fetch in progress.
REQ-015 The block SHALL have ports underrun, underrun_clr  output/input  1 each  sticky overlap flag and its clear.

Function
REQ-016 The block SHALL implement states IDLE, FETCH and DRAIN; busy SHALL be high in FETCH and DRAIN.
REQ-017 In IDLE, fetch_start SHALL latch fetch_base and move to FETCH on the next edge.
REQ-018 The block SHALL drive host_ready = (state==IDLE) && !fetch_start, combinationally; fetch always beats host.
REQ-019 A host transfer (host_valid && host_ready at edge t) SHALL drive mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_data during cycle t+1; back-to-back transfers SHALL sustain one write per cycle.
REQ-020 In FETCH, the block SHALL issue BURST_LEN consecutive reads (mem_en=1, mem_we=0) at fetch_base+i, i=0..BURST_LEN-1, with address wrapping modulo 2^AW.
REQ-021 After the last read, the block SHALL enter DRAIN for exactly one cycle, then return to IDLE.
REQ-022 For read i issued in cycle c, the block SHALL assert lb_we in cycle c+1 with lb_addr=i and lb_wdata=mem_rdata, combinationally passed through.
REQ-023 fetch_done SHALL be a one-cycle pulse in the DRAIN cycle, coincident with the final lb_we (lb_addr=BURST_LEN-1).
REQ-024 A fetch_start arriving while busy SHALL be ignored; the current burst SHALL continue unaltered.
REQ-025 A fetch_start arriving in the DRAIN cycle is also ignored, with host_ready remaining low.
REQ-026 mem_en SHALL be low in any cycle with neither a read nor an accepted host write; mem_we SHALL never be high during FETCH.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state IDLE and drive mem_en, mem_we, lb_we, fetch_done, busy and underrun to 0; mem_addr, mem_wdata and lb_addr SHALL be 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no fetch_done; the first fetch_start after release SHALL start a full burst from its own fetch_base.

Configuration
REQ-029 With macro VGA_FETCH_UNDERRUN_EN defined, each fetch_start ignored per REQ-024 and REQ-025 SHALL set underrun on the next edge; underrun SHALL hold until underrun_clr is sampled high, and a simultaneous set and clear SHALL leave it set.
REQ-030 Without VGA_FETCH_UNDERRUN_EN, underrun SHALL be constant 0 and underrun_clr SHALL be ignored; all other behaviour SHALL be identical.

Verification
REQ-031 Bench: fetch_start with fetch_base=0x0100, memory word n = n[7:0] -> reads 0x0100..0x011F on 32 consecutive cycles; lb_we writes lb_addr 0..31 with data 0x00..0x1F; fetch_done coincides with lb_addr=31; busy high for 33 cycles.
REQ-032 Bench: host_valid held with 3 writes (addr 0x10/0x11/0x12, data 0xA5/0x5A/0xFF) in IDLE -> 3 consecutive mem_we cycles with matching addr/data, host_ready high throughout.
REQ-033 Bench: fetch_start and host_valid in the same cycle -> host_ready low; host write issued only after the burst, on the first IDLE cycle; no host data lost.
REQ-034 Bench: fetch_base=0x1FF0 (AW=13) -> reads wrap from 0x1FFF to 0x0000; 32 lb writes.
REQ-035 Bench: fetch_start at burst read 10 -> ignored; burst unchanged; with VGA_FETCH_UNDERRUN_EN, underrun=1 until underrun_clr; without it, underrun stays 0.
REQ-036 Bench: rst_n low at burst read 5 -> all strobes 0 immediately; no fetch_done; next fetch_start runs a complete 32-word burst.
